// File: rtl/pc_sequencer.sv
// PC sequencer for the NPC core: a multicycle fetch/wait/execute loop that owns the architectural PC.
// Optional feature: define PC_MISALIGN_CHECK_EN to trap misaligned redirect targets to trap_vec.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h8000_0000,
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req,
  output logic [31:0] ifu_addr,
  input  logic        ifu_ready,
  input  logic        ifu_rvalid,
  input  logic [31:0] ifu_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        exu_done,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        trap_en,
  input  logic [31:0] trap_vec,
  output logic [31:0] pc,
  output logic [63:0] instret,
  output logic        fetch_err,
  output logic        misalign
);

  typedef enum logic [1:0] {
    FETCH_REQ,
    FETCH_WAIT,
    EXEC
  } state_e;

  localparam bit          TIMEOUT_EN   = (FETCH_TIMEOUT != 0);
  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_EN ? 32'(FETCH_TIMEOUT - 1) : 32'd0;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_valid_q, inst_valid_d;
  logic [63:0] instret_q, instret_d;
  logic        fetch_err_q, fetch_err_d;
  logic [31:0] cnt_q, cnt_d;
`ifdef PC_MISALIGN_CHECK_EN
  logic        misalign_q, misalign_d;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = 1'b0;
    instret_d    = instret_q;
    fetch_err_d  = 1'b0;
    cnt_d        = cnt_q;
    ifu_req      = 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
    misalign_d   = 1'b0;
`endif
    case (state_q)
      FETCH_REQ: begin
        ifu_req = 1'b1;
        if (ifu_ready) begin
          state_d = FETCH_WAIT;
          cnt_d   = 32'd0;
        end
      end
      FETCH_WAIT: begin
        // A response always wins over a timeout landing in the same cycle.
        if (ifu_rvalid) begin
          inst_d       = ifu_rdata;
          inst_valid_d = 1'b1;
          state_d      = EXEC;
        end else if (TIMEOUT_EN && (cnt_q == TIMEOUT_LAST)) begin
          fetch_err_d = 1'b1;
          pc_d        = trap_vec;
          state_d     = FETCH_REQ;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      EXEC: begin
        if (exu_done) begin
          state_d = FETCH_REQ;
          if (trap_en) begin
            pc_d = trap_vec;
          end else if (redirect_en) begin
`ifdef PC_MISALIGN_CHECK_EN
            if (redirect_pc[1:0] != 2'b00) begin
              pc_d       = trap_vec;
              misalign_d = 1'b1;
            end else begin
              pc_d      = redirect_pc;
              instret_d = instret_q + 64'd1;
            end
`else
            pc_d      = redirect_pc & 32'hFFFF_FFFC;
            instret_d = instret_q + 64'd1;
`endif
          end else begin
            pc_d      = pc_q + 32'd4;
            instret_d = instret_q + 64'd1;
          end
        end
      end
      default: state_d = FETCH_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH_REQ;
      pc_q         <= RESET_PC;
      inst_q       <= 32'd0;
      inst_valid_q <= 1'b0;
      instret_q    <= 64'd0;
      fetch_err_q  <= 1'b0;
      cnt_q        <= 32'd0;
`ifdef PC_MISALIGN_CHECK_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      instret_q    <= instret_d;
      fetch_err_q  <= fetch_err_d;
      cnt_q        <= cnt_d;
`ifdef PC_MISALIGN_CHECK_EN
      misalign_q   <= misalign_d;
`endif
    end
  end

  assign ifu_addr   = pc_q;
  assign pc         = pc_q;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign instret    = instret_q;
  assign fetch_err  = fetch_err_q;
`ifdef PC_MISALIGN_CHECK_EN
  assign misalign   = misalign_q;
`else
  assign misalign   = 1'b0;
`endif

endmodule
